axi4_spi_bridge_rr: RTL and testbench
=====================================

Name: axi4_spi_bridge_rr

Overview:
Single-clock AXI4 slave that converts AXI4 read and write bursts into single-beat requests on the SPI controller request interface (spi_*). It is the successor to the dual-clock FIFO bridge. It adds:
- parametrised data width with a derived strobe width
- INCR and FIXED bursts
- an address-window decode with DECERR
- per-access timeout with SLVERR
- round-robin read/write arbitration
- worst-case merging of B responses
It sits between the AXI interconnect and the SPI master controller when both run on one clock.

Parameters:
DATA_WIDTH, 32, AXI/SPI data width; must be a multiple of 8 and no less than 8
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, AXI ID width
BASE_ADDR, 32'h0000_0000, lowest decoded address
ADDR_SPAN, 32'h0001_0000, decoded window size in bytes
TIMEOUT_CYCLES, 1024, cycles to wait for spi_*_done; 0 disables the timeout
TO_WIDTH, 16, timeout counter width

Ports:
m_clk  in  1  clock
m_rst  in  1  synchronous active-high reset
m_aw_addr/m_aw_id/m_aw_len/m_aw_burst  in  ADDR_WIDTH/ID_WIDTH/8/2  write address channel
m_aw_valid  in  1 ; m_aw_ready  out  1
m_w_data/m_w_strb/m_w_last  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
m_w_valid  in  1 ; m_w_ready  out  1
m_b_id/m_b_resp/m_b_valid  out  ID_WIDTH/2/1 ; m_b_ready  in  1
m_ar_addr/m_ar_id/m_ar_len/m_ar_burst  in  ADDR_WIDTH/ID_WIDTH/8/2  read address channel
m_ar_valid  in  1 ; m_ar_ready  out  1
m_r_data/m_r_id/m_r_resp/m_r_last/m_r_valid  out  DATA_WIDTH/ID_WIDTH/2/1/1 ; m_r_ready  in  1
spi_addr/spi_wr_data/spi_wr_strb  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  SPI request fields
spi_wr_valid, spi_rd_valid  out  1  request strobes, held until done or timeout
spi_ready  in  1 ; spi_rd_data  in  DATA_WIDTH ; spi_rd_done, spi_wr_done  in  1 ; spi_resp  in  2

Behaviour:
- Clocking and reset: one clock, m_clk. Reset m_rst is synchronous and active-high. With m_rst high at a m_clk edge, every output goes to 0 and the FSM goes to IDLE; the last-grant flag is set to READ. A reset during any transaction abandons it and no B/R response is issued.
- States: IDLE, W_GET, W_REQ, W_DRAIN, B_RESP, R_REQ, R_RESP.
- m_aw_ready / m_ar_ready: combinational.
  - m_aw_ready = (state==IDLE) && m_aw_valid && grant_wr
  - m_ar_ready = (state==IDLE) && m_ar_valid && !grant_wr
- Arbitration, grant_wr:
  - only AW valid -> write; only AR valid -> read.
  - both valid -> the channel not granted last. After reset, the first contention grants write.
  - last-grant updates on each AW/AR handshake.
- AW handshake: latch addr, id, len, burst; clear beat counter; set bresp_acc=OKAY.
  - burst 2'b10 or 2'b11 (unsupported) -> whole burst is SLVERR with no SPI access; W beats are drained.
  - addr outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) -> whole burst is DECERR, drained the same way.
  - next state: W_DRAIN in both error cases, else W_GET.
- W_GET: m_w_ready=1.
  - On handshake, register data/strb into spi_wr_data/spi_wr_strb and drive spi_addr = current beat address.
  - If spi_ready is high, assert spi_wr_valid and go to W_REQ.
  - If spi_ready is low, hold W_GET with m_w_ready=0 until spi_ready rises, then assert spi_wr_valid.
- W_REQ: spi_wr_valid stays high until spi_wr_done or timeout.
  - Done: bresp_acc = max(bresp_acc, spi_resp); drop valid.
  - Timeout: bresp_acc = max(bresp_acc, 2'b10); drop valid.
  - Then: if the beat had m_w_last high, or the beat counter == len -> B_RESP; else increment the counter and go to W_GET.
  - m_w_last is trusted over len.
- W_DRAIN: m_w_ready=1, beats are discarded; on m_w_last -> B_RESP.
- B_RESP: m_b_valid=1, m_b_id=latched id, m_b_resp=bresp_acc. Held until m_b_ready, then IDLE.
- AR handshake: address/burst decode as for AW.
  - Error beats skip SPI and return m_r_data=0 with resp DECERR/SLVERR.
- R_REQ: spi_rd_valid is asserted once spi_ready is seen.
  - On spi_rd_done: capture spi_rd_data and spi_resp.
  - On timeout: data=0, resp=SLVERR.
  - Go to R_RESP.
- R_RESP: m_r_valid=1, m_r_last = (beat counter == len). Held stable until m_r_ready.
  - Then: if last -> IDLE; else increment the counter and go to R_REQ.
- Beat address:
  - INCR: addr + beat*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH; the window is decoded on the start address only.
  - FIXED: the start address for every beat.
- Timeout counter: cleared on entry to W_REQ/R_REQ, increments each cycle. It fires when it equals TIMEOUT_CYCLES-1 with no done. Disabled when TIMEOUT_CYCLES==0.
- A done seen in the same cycle as the timeout is treated as done.
- spi_wr_valid and spi_rd_valid are never both high. Stray done pulses outside W_REQ/R_REQ are ignored.

Test Plan:
1. INCR write at 0x100, len=3, 4 beats, spi_wr_done after 2 cycles, resp OKAY -> spi_addr 0x100,0x104,0x108,0x10C; one B with resp=OKAY and matching id.
2. FIXED read at 0x40, len=2, spi_rd_data 0xA,0xB,0xC -> spi_addr 0x40 three times; R data A,B,C; m_r_last only on the third beat.
3. AW and AR valid together in consecutive IDLE windows after reset -> grant order write, read, write.
4. Write to BASE_ADDR+ADDR_SPAN, len=1 -> no spi_wr_valid; both W beats accepted; B resp=2'b11.
5. Read with TIMEOUT_CYCLES=8 and spi_rd_done never asserted -> spi_rd_valid drops after 8 cycles; R resp=2'b10, data=0.
6. m_rst asserted mid-write in W_REQ -> next cycle all outputs 0 and state IDLE; no B issued; the next AW is accepted normally.

Source files
------------

// File: rtl/axi4_spi_bridge_rr.sv
// axi4_spi_bridge_rr: single-clock AXI4 slave that turns INCR/FIXED bursts into
// single-beat SPI controller requests. It decodes an address window, times out
// stalled accesses, arbitrates AW/AR round-robin and merges B responses worst-case.
module axi4_spi_bridge_rr #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    ID_WIDTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0001_0000,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    TO_WIDTH       = 16
) (
  input  logic                    m_clk,
  input  logic                    m_rst,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   m_aw_addr,
  input  logic [ID_WIDTH-1:0]     m_aw_id,
  input  logic [7:0]              m_aw_len,
  input  logic [1:0]              m_aw_burst,
  input  logic                    m_aw_valid,
  output logic                    m_aw_ready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   m_w_data,
  input  logic [DATA_WIDTH/8-1:0] m_w_strb,
  input  logic                    m_w_last,
  input  logic                    m_w_valid,
  output logic                    m_w_ready,
  // write response channel
  output logic [ID_WIDTH-1:0]     m_b_id,
  output logic [1:0]              m_b_resp,
  output logic                    m_b_valid,
  input  logic                    m_b_ready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   m_ar_addr,
  input  logic [ID_WIDTH-1:0]     m_ar_id,
  input  logic [7:0]              m_ar_len,
  input  logic [1:0]              m_ar_burst,
  input  logic                    m_ar_valid,
  output logic                    m_ar_ready,
  // read data channel
  output logic [DATA_WIDTH-1:0]   m_r_data,
  output logic [ID_WIDTH-1:0]     m_r_id,
  output logic [1:0]              m_r_resp,
  output logic                    m_r_last,
  output logic                    m_r_valid,
  input  logic                    m_r_ready,
  // SPI controller request interface
  output logic [ADDR_WIDTH-1:0]   spi_addr,
  output logic [DATA_WIDTH-1:0]   spi_wr_data,
  output logic [DATA_WIDTH/8-1:0] spi_wr_strb,
  output logic                    spi_wr_valid,
  output logic                    spi_rd_valid,
  input  logic                    spi_ready,
  input  logic [DATA_WIDTH-1:0]   spi_rd_data,
  input  logic                    spi_rd_done,
  input  logic                    spi_wr_done,
  input  logic [1:0]              spi_resp
);

  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  // Window bounds carry one extra bit so BASE_ADDR+ADDR_SPAN may reach 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_GET   = 3'd1,
    W_REQ   = 3'd2,
    W_DRAIN = 3'd3,
    B_RESP  = 3'd4,
    R_REQ   = 3'd5,
    R_RESP  = 3'd6
  } state_e;

  // Worse of two AXI responses; the encoding orders them by severity.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Burst-level error for a start address: unsupported burst types win over decode misses.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [1:0]            burst);
    logic [ADDR_WIDTH:0] a_ext;
    a_ext = {1'b0, addr};
    if (burst[1]) begin
      return RESP_SLVERR;
    end else if ((a_ext < WIN_LO) || (a_ext >= WIN_HI)) begin
      return RESP_DECERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ID_WIDTH-1:0]     id_r;
  logic [7:0]              len_r;
  logic [1:0]              burst_r;
  logic [7:0]              beat_r;
  logic [1:0]              err_r;
  logic [1:0]              bresp_acc_r;
  logic                    w_last_r;
  logic [TO_WIDTH-1:0]     to_cnt_r;
  logic                    last_wr_r;

  logic                    grant_wr_s;
  logic                    aw_hs_s;
  logic                    ar_hs_s;
  logic                    w_hs_s;
  logic                    b_hs_s;
  logic                    r_hs_s;
  logic [1:0]              aw_dec_s;
  logic [1:0]              ar_dec_s;
  logic [ADDR_WIDTH-1:0]   beat_addr_s;
  logic                    to_fire_s;
  logic                    wr_fin_s;
  logic                    rd_fin_s;
  logic                    beat_last_s;
  logic [1:0]              wr_resp_s;

  assign grant_wr_s  = m_aw_valid && (!m_ar_valid || !last_wr_r);
  assign aw_hs_s     = m_aw_valid && m_aw_ready;
  assign ar_hs_s     = m_ar_valid && m_ar_ready;
  assign w_hs_s      = m_w_valid && m_w_ready;
  assign b_hs_s      = m_b_valid && m_b_ready;
  assign r_hs_s      = m_r_valid && m_r_ready;
  assign aw_dec_s    = decode_resp(m_aw_addr, m_aw_burst);
  assign ar_dec_s    = decode_resp(m_ar_addr, m_ar_burst);
  assign beat_addr_s = (burst_r == BURST_FIXED) ? addr_r
                     : addr_r + (ADDR_WIDTH'(beat_r) * ADDR_WIDTH'(BYTES));
  assign to_fire_s   = (TIMEOUT_CYCLES != 0) && (to_cnt_r == TO_LAST);
  assign wr_fin_s    = (state_r == W_REQ) && spi_wr_valid && (spi_wr_done || to_fire_s);
  assign rd_fin_s    = (state_r == R_REQ) && spi_rd_valid && (spi_rd_done || to_fire_s);
  assign beat_last_s = (beat_r == len_r);
  // A done in the timeout cycle counts as done.
  assign wr_resp_s   = resp_max(bresp_acc_r, spi_wr_done ? spi_resp : RESP_SLVERR);

  // State register with synchronous reset.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
          state_nxt_s = (aw_dec_s != RESP_OKAY) ? W_DRAIN : W_GET;
        end else if (ar_hs_s) begin
          state_nxt_s = R_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      W_GET: begin
        if (w_hs_s) begin
          state_nxt_s = W_REQ;
        end else begin
          state_nxt_s = W_GET;
        end
      end
      W_REQ: begin
        if (wr_fin_s) begin
          state_nxt_s = (w_last_r || beat_last_s) ? B_RESP : W_GET;
        end else begin
          state_nxt_s = W_REQ;
        end
      end
      W_DRAIN: begin
        if (w_hs_s && m_w_last) begin
          state_nxt_s = B_RESP;
        end else begin
          state_nxt_s = W_DRAIN;
        end
      end
      B_RESP: begin
        if (b_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = B_RESP;
        end
      end
      R_REQ: begin
        if ((err_r != RESP_OKAY) || rd_fin_s) begin
          state_nxt_s = R_RESP;
        end else begin
          state_nxt_s = R_REQ;
        end
      end
      R_RESP: begin
        if (r_hs_s) begin
          state_nxt_s = beat_last_s ? IDLE : R_REQ;
        end else begin
          state_nxt_s = R_RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Combinational ready outputs; forced low while reset is asserted.
  always_comb begin
    m_aw_ready = 1'b0;
    m_ar_ready = 1'b0;
    m_w_ready  = 1'b0;
    if (m_rst) begin
      m_aw_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          m_aw_ready = m_aw_valid && grant_wr_s;
          m_ar_ready = m_ar_valid && !grant_wr_s;
        end
        W_GET:   m_w_ready = spi_ready;
        W_DRAIN: m_w_ready = 1'b1;
        default: m_w_ready = 1'b0;
      endcase
    end
  end

  // Burst context, SPI request and AXI response registers.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      addr_r       <= '0;
      id_r         <= '0;
      len_r        <= 8'd0;
      burst_r      <= 2'b00;
      beat_r       <= 8'd0;
      err_r        <= RESP_OKAY;
      bresp_acc_r  <= RESP_OKAY;
      w_last_r     <= 1'b0;
      to_cnt_r     <= '0;
      last_wr_r    <= 1'b0;
      spi_addr     <= '0;
      spi_wr_data  <= '0;
      spi_wr_strb  <= '0;
      spi_wr_valid <= 1'b0;
      spi_rd_valid <= 1'b0;
      m_b_id       <= '0;
      m_b_resp     <= 2'b00;
      m_b_valid    <= 1'b0;
      m_r_data     <= '0;
      m_r_id       <= '0;
      m_r_resp     <= 2'b00;
      m_r_last     <= 1'b0;
      m_r_valid    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (aw_hs_s) begin
            addr_r      <= m_aw_addr;
            id_r        <= m_aw_id;
            len_r       <= m_aw_len;
            burst_r     <= m_aw_burst;
            beat_r      <= 8'd0;
            err_r       <= aw_dec_s;
            bresp_acc_r <= aw_dec_s;
            last_wr_r   <= 1'b1;
          end else if (ar_hs_s) begin
            addr_r      <= m_ar_addr;
            id_r        <= m_ar_id;
            len_r       <= m_ar_len;
            burst_r     <= m_ar_burst;
            beat_r      <= 8'd0;
            err_r       <= ar_dec_s;
            last_wr_r   <= 1'b0;
          end
        end
        W_GET: begin
          if (w_hs_s) begin
            spi_wr_data  <= m_w_data;
            spi_wr_strb  <= m_w_strb;
            spi_addr     <= beat_addr_s;
            spi_wr_valid <= 1'b1;
            w_last_r     <= m_w_last;
            to_cnt_r     <= '0;
          end
        end
        W_REQ: begin
          if (wr_fin_s) begin
            spi_wr_valid <= 1'b0;
            bresp_acc_r  <= wr_resp_s;
            if (w_last_r || beat_last_s) begin
              m_b_valid <= 1'b1;
              m_b_id    <= id_r;
              m_b_resp  <= wr_resp_s;
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end else begin
            to_cnt_r <= to_cnt_r + TO_WIDTH'(1'b1);
          end
        end
        W_DRAIN: begin
          if (w_hs_s && m_w_last) begin
            m_b_valid <= 1'b1;
            m_b_id    <= id_r;
            m_b_resp  <= bresp_acc_r;
          end
        end
        B_RESP: begin
          if (b_hs_s) begin
            m_b_valid <= 1'b0;
          end
        end
        R_REQ: begin
          if (err_r != RESP_OKAY) begin
            m_r_valid <= 1'b1;
            m_r_data  <= '0;
            m_r_resp  <= err_r;
            m_r_last  <= beat_last_s;
            m_r_id    <= id_r;
          end else if (!spi_rd_valid) begin
            if (spi_ready) begin
              spi_rd_valid <= 1'b1;
              spi_addr     <= beat_addr_s;
              to_cnt_r     <= '0;
            end
          end else if (rd_fin_s) begin
            spi_rd_valid <= 1'b0;
            m_r_valid    <= 1'b1;
            m_r_data     <= spi_rd_done ? spi_rd_data : '0;
            m_r_resp     <= spi_rd_done ? spi_resp : RESP_SLVERR;
            m_r_last     <= beat_last_s;
            m_r_id       <= id_r;
          end else begin
            to_cnt_r <= to_cnt_r + TO_WIDTH'(1'b1);
          end
        end
        R_RESP: begin
          if (r_hs_s) begin
            m_r_valid <= 1'b0;
            if (!beat_last_s) begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        default: begin
          spi_wr_valid <= 1'b0;
          spi_rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_spi_bridge_rr.sv
// tb_axi4_spi_bridge_rr: directed bench for the AXI4-to-SPI bridge with hand-computed expectations.
module tb_axi4_spi_bridge_rr;

  logic        m_clk = 1'b0;
  logic        m_rst;
  logic [31:0] m_aw_addr;
  logic [3:0]  m_aw_id;
  logic [7:0]  m_aw_len;
  logic [1:0]  m_aw_burst;
  logic        m_aw_valid;
  logic        m_aw_ready;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_w_last;
  logic        m_w_valid;
  logic        m_w_ready;
  logic [3:0]  m_b_id;
  logic [1:0]  m_b_resp;
  logic        m_b_valid;
  logic        m_b_ready;
  logic [31:0] m_ar_addr;
  logic [3:0]  m_ar_id;
  logic [7:0]  m_ar_len;
  logic [1:0]  m_ar_burst;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_r_data;
  logic [3:0]  m_r_id;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic        m_r_valid;
  logic        m_r_ready;
  logic [31:0] spi_addr;
  logic [31:0] spi_wr_data;
  logic [3:0]  spi_wr_strb;
  logic        spi_wr_valid;
  logic        spi_rd_valid;
  logic        spi_ready;
  logic [31:0] spi_rd_data;
  logic        spi_rd_done;
  logic        spi_wr_done;
  logic [1:0]  spi_resp;

  int errors = 0;
  int checks = 0;
  int wr_req_cnt = 0;
  int rd_req_cnt = 0;
  logic wr_v_d = 1'b0;
  logic rd_v_d = 1'b0;

  axi4_spi_bridge_rr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4),
    .BASE_ADDR(32'h0000_0000), .ADDR_SPAN(32'h0001_0000),
    .TIMEOUT_CYCLES(8), .TO_WIDTH(16)
  ) dut (
    .m_clk(m_clk), .m_rst(m_rst),
    .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id), .m_aw_len(m_aw_len), .m_aw_burst(m_aw_burst),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_burst(m_ar_burst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .spi_addr(spi_addr), .spi_wr_data(spi_wr_data), .spi_wr_strb(spi_wr_strb),
    .spi_wr_valid(spi_wr_valid), .spi_rd_valid(spi_rd_valid), .spi_ready(spi_ready),
    .spi_rd_data(spi_rd_data), .spi_rd_done(spi_rd_done), .spi_wr_done(spi_wr_done),
    .spi_resp(spi_resp)
  );

  always #5 m_clk = ~m_clk;

  // Count SPI request starts (rising edges of the request strobes).
  always @(posedge m_clk) begin
    wr_v_d <= spi_wr_valid;
    rd_v_d <= spi_rd_valid;
    if (spi_wr_valid && !wr_v_d) wr_req_cnt <= wr_req_cnt + 1;
    if (spi_rd_valid && !rd_v_d) rd_req_cnt <= rd_req_cnt + 1;
  end

  task automatic tick;
    @(negedge m_clk);
  endtask

  task automatic clear_inputs;
    m_aw_addr = 32'h0; m_aw_id = 4'h0; m_aw_len = 8'h0; m_aw_burst = 2'b00; m_aw_valid = 1'b0;
    m_w_data = 32'h0; m_w_strb = 4'h0; m_w_last = 1'b0; m_w_valid = 1'b0;
    m_b_ready = 1'b0;
    m_ar_addr = 32'h0; m_ar_id = 4'h0; m_ar_len = 8'h0; m_ar_burst = 2'b00; m_ar_valid = 1'b0;
    m_r_ready = 1'b0;
    spi_ready = 1'b1; spi_rd_data = 32'h0; spi_rd_done = 1'b0; spi_wr_done = 1'b0; spi_resp = 2'b00;
  endtask

  task automatic do_reset;
    m_rst = 1'b1;
    clear_inputs();
    tick(); tick();
    m_rst = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    m_aw_addr = a; m_aw_id = id; m_aw_len = len; m_aw_burst = burst; m_aw_valid = 1'b1;
    #1; n = 0;
    while (!m_aw_ready && n < 50) begin tick(); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL aw_handshake: m_aw_ready=%b required 1 within 50 cycles", m_aw_ready);
    end
    tick(); m_aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    m_ar_addr = a; m_ar_id = id; m_ar_len = len; m_ar_burst = burst; m_ar_valid = 1'b1;
    #1; n = 0;
    while (!m_ar_ready && n < 50) begin tick(); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL ar_handshake: m_ar_ready=%b required 1 within 50 cycles", m_ar_ready);
    end
    tick(); m_ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    m_w_data = d; m_w_strb = strb; m_w_last = last; m_w_valid = 1'b1;
    #1; n = 0;
    while (!m_w_ready && n < 50) begin tick(); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL w_handshake: m_w_ready=%b required 1 within 50 cycles", m_w_ready);
    end
    tick(); m_w_valid = 1'b0; m_w_last = 1'b0;
  endtask

  task automatic spi_wr_serve(input int dly, input logic [1:0] resp,
                              output logic [31:0] a, output logic [31:0] d);
    int n;
    n = 0;
    while (!spi_wr_valid && n < 50) begin tick(); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL spi_wr_valid_wait: spi_wr_valid=%b required 1 within 50 cycles", spi_wr_valid);
    end
    a = spi_addr; d = spi_wr_data;
    repeat (dly) tick();
    spi_wr_done = 1'b1; spi_resp = resp;
    tick();
    spi_wr_done = 1'b0; spi_resp = 2'b00;
  endtask

  task automatic spi_rd_serve(input logic [31:0] d, output logic [31:0] a);
    int n;
    n = 0;
    while (!spi_rd_valid && n < 50) begin tick(); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL spi_rd_valid_wait: spi_rd_valid=%b required 1 within 50 cycles", spi_rd_valid);
    end
    a = spi_addr;
    spi_rd_done = 1'b1; spi_rd_data = d; spi_resp = 2'b00;
    tick();
    spi_rd_done = 1'b0; spi_rd_data = 32'h0;
  endtask

  task automatic b_wait_ack(input logic [3:0] exp_id, input logic [1:0] exp_resp, input string tag);
    int n;
    n = 0;
    while (!m_b_valid && n < 50) begin tick(); n++; end
    checks++;
    if (m_b_valid !== 1'b1 || m_b_id !== exp_id || m_b_resp !== exp_resp) begin
      errors++;
      $display("FAIL %s_b: valid=%b id=%h resp=%b required valid=1 id=%h resp=%b",
               tag, m_b_valid, m_b_id, m_b_resp, exp_id, exp_resp);
    end
    m_b_ready = 1'b1; tick(); m_b_ready = 1'b0;
  endtask

  task automatic r_wait_ack(input logic [31:0] exp_d, input logic [3:0] exp_id,
                            input logic [1:0] exp_resp, input logic exp_last, input string tag);
    int n;
    n = 0;
    while (!m_r_valid && n < 50) begin tick(); n++; end
    checks++;
    if (m_r_valid !== 1'b1 || m_r_data !== exp_d || m_r_id !== exp_id ||
        m_r_resp !== exp_resp || m_r_last !== exp_last) begin
      errors++;
      $display("FAIL %s_r: valid=%b data=%h id=%h resp=%b last=%b required valid=1 data=%h id=%h resp=%b last=%b",
               tag, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last, exp_d, exp_id, exp_resp, exp_last);
    end
    m_r_ready = 1'b1; tick(); m_r_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [19:0] ctl;
    m_rst = 1'b1;
    clear_inputs();
    tick(); tick();
    ctl = {m_aw_ready, m_w_ready, m_b_valid, m_b_id, m_b_resp, m_ar_ready, m_r_valid,
           m_r_last, m_r_resp, m_r_id, spi_wr_valid, spi_rd_valid};
    checks++;
    if (ctl !== 20'h0) begin errors++; $display("FAIL reset_ctl: got %h required 0", ctl); end
    checks++;
    if ({spi_addr, spi_wr_data, spi_wr_strb, m_r_data} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h strb=%h rdata=%h required 0",
               spi_addr, spi_wr_data, spi_wr_strb, m_r_data);
    end
    m_rst = 1'b0;
    tick();
  endtask

  task automatic test_incr_write;
    logic [31:0] a, d, exp_d;
    aw_send(32'h0000_0100, 4'h5, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) begin
      exp_d = 32'hA000_0000 + 32'(b);
      if (b == 2) begin
        spi_ready = 1'b0;
        m_w_data = exp_d; m_w_strb = 4'hF; m_w_valid = 1'b1;
        tick(); tick();
        checks++;
        if (m_w_ready !== 1'b0 || spi_wr_valid !== 1'b0) begin
          errors++;
          $display("FAIL wget_hold: w_ready=%b wr_valid=%b required 0 0", m_w_ready, spi_wr_valid);
        end
        spi_ready = 1'b1;
      end
      w_send(exp_d, 4'hF, (b == 3));
      spi_wr_serve(2, 2'b00, a, d);
      checks++;
      if (a !== 32'h0000_0100 + 32'(4 * b) || d !== exp_d) begin
        errors++;
        $display("FAIL incr_wr_beat%0d: addr=%h data=%h required addr=%h data=%h",
                 b, a, d, 32'h0000_0100 + 32'(4 * b), exp_d);
      end
    end
    b_wait_ack(4'h5, 2'b00, "incr_wr");
    checks++;
    if (m_b_valid !== 1'b0) begin errors++; $display("FAIL incr_wr_b_drop: got %b required 0", m_b_valid); end
  endtask

  task automatic test_fixed_read;
    logic [31:0] a;
    ar_send(32'h0000_0040, 4'h3, 8'd2, 2'b00);
    for (int b = 0; b < 3; b++) begin
      spi_rd_serve(32'hA + 32'(b), a);
      checks++;
      if (a !== 32'h0000_0040) begin
        errors++; $display("FAIL fixed_rd_addr%0d: got %h required 00000040", b, a);
      end
      r_wait_ack(32'hA + 32'(b), 4'h3, 2'b00, (b == 2), "fixed_rd");
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] a, d;
    do_reset();
    m_ar_addr = 32'h300; m_ar_id = 4'h1; m_ar_len = 8'd0; m_ar_burst = 2'b01; m_ar_valid = 1'b1;
    m_aw_addr = 32'h200; m_aw_id = 4'h2; m_aw_len = 8'd0; m_aw_burst = 2'b01; m_aw_valid = 1'b1;
    #1;
    checks++;
    if (m_aw_ready !== 1'b1 || m_ar_ready !== 1'b0) begin
      errors++; $display("FAIL grant1: aw_ready=%b ar_ready=%b required 1 0", m_aw_ready, m_ar_ready);
    end
    tick(); m_aw_valid = 1'b0;
    w_send(32'h1111_1111, 4'hF, 1'b1);
    spi_wr_serve(0, 2'b00, a, d);
    b_wait_ack(4'h2, 2'b00, "arb_wr1");
    m_aw_valid = 1'b1; #1;
    checks++;
    if (m_aw_ready !== 1'b0 || m_ar_ready !== 1'b1) begin
      errors++; $display("FAIL grant2: aw_ready=%b ar_ready=%b required 0 1", m_aw_ready, m_ar_ready);
    end
    tick(); m_ar_valid = 1'b0;
    spi_rd_serve(32'h0000_0055, a);
    r_wait_ack(32'h0000_0055, 4'h1, 2'b00, 1'b1, "arb_rd");
    m_ar_valid = 1'b1; #1;
    checks++;
    if (m_aw_ready !== 1'b1 || m_ar_ready !== 1'b0) begin
      errors++; $display("FAIL grant3: aw_ready=%b ar_ready=%b required 1 0", m_aw_ready, m_ar_ready);
    end
    tick(); m_aw_valid = 1'b0;
    w_send(32'h2222_2222, 4'hF, 1'b1);
    spi_wr_serve(0, 2'b00, a, d);
    b_wait_ack(4'h2, 2'b00, "arb_wr2");
    #1;
    checks++;
    if (m_ar_ready !== 1'b1) begin
      errors++; $display("FAIL grant4: ar_ready=%b required 1", m_ar_ready);
    end
    tick(); m_ar_valid = 1'b0;
    spi_rd_serve(32'h0000_0066, a);
    r_wait_ack(32'h0000_0066, 4'h1, 2'b00, 1'b1, "arb_rd2");
  endtask

  task automatic test_errors;
    int wc, rc;
    wc = wr_req_cnt; rc = rd_req_cnt;
    aw_send(32'h0001_0000, 4'h2, 8'd1, 2'b01);
    w_send(32'hDEAD_0000, 4'hF, 1'b0);
    w_send(32'hDEAD_0001, 4'hF, 1'b1);
    b_wait_ack(4'h2, 2'b11, "decerr_wr");
    aw_send(32'h0000_0100, 4'h6, 8'd0, 2'b10);
    w_send(32'hBEEF_0000, 4'hF, 1'b1);
    b_wait_ack(4'h6, 2'b10, "slverr_wr");
    ar_send(32'h0002_0000, 4'h4, 8'd1, 2'b01);
    r_wait_ack(32'h0, 4'h4, 2'b11, 1'b0, "decerr_rd0");
    r_wait_ack(32'h0, 4'h4, 2'b11, 1'b1, "decerr_rd1");
    checks++;
    if (wr_req_cnt !== wc || rd_req_cnt !== rc) begin
      errors++;
      $display("FAIL err_no_spi: wr_reqs=%0d rd_reqs=%0d required %0d %0d", wr_req_cnt, rd_req_cnt, wc, rc);
    end
  endtask

  task automatic test_merge;
    logic [31:0] a, d;
    aw_send(32'h0000_0100, 4'h9, 8'd1, 2'b01);
    w_send(32'h3333_0000, 4'h3, 1'b0);
    spi_wr_serve(1, 2'b10, a, d);
    w_send(32'h3333_0001, 4'hC, 1'b1);
    spi_wr_serve(1, 2'b01, a, d);
    checks++;
    if (a !== 32'h0000_0104 || spi_wr_strb !== 4'hC) begin
      errors++; $display("FAIL merge_beat1: addr=%h strb=%h required 00000104 c", a, spi_wr_strb);
    end
    b_wait_ack(4'h9, 2'b10, "merge");
  endtask

  task automatic test_timeout;
    int n, w;
    ar_send(32'h0000_0080, 4'h1, 8'd0, 2'b01);
    w = 0;
    while (!spi_rd_valid && w < 50) begin tick(); w++; end
    n = 0;
    while (spi_rd_valid && n < 50) begin n++; tick(); end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL timeout_len: valid cycles=%0d required 8", n); end
    r_wait_ack(32'h0, 4'h1, 2'b10, 1'b1, "timeout_rd");
    // Done arriving in the very cycle the timeout fires must win.
    ar_send(32'h0000_0084, 4'h2, 8'd0, 2'b01);
    w = 0;
    while (!spi_rd_valid && w < 50) begin tick(); w++; end
    repeat (7) tick();
    spi_rd_done = 1'b1; spi_rd_data = 32'h0000_0077; spi_resp = 2'b00;
    tick();
    spi_rd_done = 1'b0; spi_rd_data = 32'h0;
    r_wait_ack(32'h0000_0077, 4'h2, 2'b00, 1'b1, "done_at_timeout");
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] a, d;
    int w;
    aw_send(32'h0000_0100, 4'h7, 8'd1, 2'b01);
    w_send(32'h4444_4444, 4'hF, 1'b0);
    w = 0;
    while (!spi_wr_valid && w < 50) begin tick(); w++; end
    m_rst = 1'b1;
    tick();
    checks++;
    if ({spi_wr_valid, m_w_ready, m_b_valid, m_aw_ready, spi_wr_strb} !== 8'h0 ||
        spi_addr !== 32'h0 || spi_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: wr_valid=%b w_ready=%b b_valid=%b addr=%h data=%h required 0",
               spi_wr_valid, m_w_ready, m_b_valid, spi_addr, spi_wr_data);
    end
    m_rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (m_b_valid !== 1'b0 || spi_wr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_b: b_valid=%b wr_valid=%b required 0 0", m_b_valid, spi_wr_valid);
    end
    aw_send(32'h0000_0200, 4'h8, 8'd0, 2'b01);
    w_send(32'h5555_5555, 4'hF, 1'b1);
    spi_wr_serve(0, 2'b00, a, d);
    checks++;
    if (a !== 32'h0000_0200 || d !== 32'h5555_5555) begin
      errors++; $display("FAIL post_reset_wr: addr=%h data=%h required 00000200 55555555", a, d);
    end
    b_wait_ack(4'h8, 2'b00, "post_reset");
  endtask

  initial begin
    test_reset();
    test_incr_write();
    test_fixed_read();
    test_arbitration();
    test_errors();
    test_merge();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
